// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: one pipeline stage register with valid/ready handshake.
// The output entry is always registered. When the stage is empty, the output shows
// the bubble pattern: zero control and BUBBLE_BYTE repeated across the data field.
// Build option PIPELINE_SKID_BUFFER_EN:
//   defined   - two entries (output plus skid). In_Ready is a registered "not FULL".
//   undefined - a single entry. In_Ready = !Out_Valid || Out_Ready.
module pipeline_stage_register #(
    parameter int         CTRL_W      = 12,
    parameter int         DATA_W      = 192,
    parameter logic [7:0] BUBBLE_BYTE = 8'h2A
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    localparam entry_t BUBBLE = '{ctrl: '0, data: {(DATA_W/8){BUBBLE_BYTE}}};

    state_t     state;
    entry_t     out_q;
    logic       out_vld_q;
    logic [1:0] occ_q;
    entry_t     in_ent;
    logic       push;
    logic       pop;

    assign in_ent    = '{ctrl: In_Ctrl, data: In_Data};
    assign push      = In_Valid && In_Ready;
    assign pop       = out_vld_q && Out_Ready;

    assign Out_Valid = out_vld_q;
    assign Out_Ctrl  = out_q.ctrl;
    assign Out_Data  = out_q.data;
    assign Occupancy = occ_q;

`ifdef PIPELINE_SKID_BUFFER_EN
    entry_t skid_q;
    logic   in_rdy_q;

    // In_Ready comes straight from a register. This keeps Out_Ready from
    // rippling back to the upstream stage within the same cycle.
    assign In_Ready = in_rdy_q;

    // Two-entry state machine. The output entry always holds the oldest entry;
    // the skid entry catches the one push that was accepted during a stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= EMPTY;
            out_q     <= BUBBLE;
            skid_q    <= BUBBLE;
            out_vld_q <= 1'b0;
            occ_q     <= 2'd0;
            in_rdy_q  <= 1'b1;
        end else if (Flush) begin
            state     <= EMPTY;
            out_q     <= BUBBLE;
            skid_q    <= BUBBLE;
            out_vld_q <= 1'b0;
            occ_q     <= 2'd0;
            in_rdy_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_q     <= in_ent;
                        out_vld_q <= 1'b1;
                        occ_q     <= 2'd1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_q <= in_ent;
                    end else if (push) begin
                        skid_q   <= in_ent;
                        occ_q    <= 2'd2;
                        in_rdy_q <= 1'b0;
                        state    <= FULL;
                    end else if (pop) begin
                        out_q     <= BUBBLE;
                        out_vld_q <= 1'b0;
                        occ_q     <= 2'd0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_q    <= skid_q;
                        skid_q   <= BUBBLE;
                        occ_q    <= 2'd1;
                        in_rdy_q <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_q     <= BUBBLE;
                    skid_q    <= BUBBLE;
                    out_vld_q <= 1'b0;
                    occ_q     <= 2'd0;
                    in_rdy_q  <= 1'b1;
                end
            endcase
        end
    end
`else
    // Single entry: an entry may enter on the same edge the held one leaves.
    assign In_Ready = !out_vld_q || Out_Ready;

    // Single-entry state machine. FULL is never entered in this build.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= EMPTY;
            out_q     <= BUBBLE;
            out_vld_q <= 1'b0;
            occ_q     <= 2'd0;
        end else if (Flush) begin
            state     <= EMPTY;
            out_q     <= BUBBLE;
            out_vld_q <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_q     <= in_ent;
                        out_vld_q <= 1'b1;
                        occ_q     <= 2'd1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push) begin
                        out_q <= in_ent;
                    end else if (pop) begin
                        out_q     <= BUBBLE;
                        out_vld_q <= 1'b0;
                        occ_q     <= 2'd0;
                        state     <= EMPTY;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_q     <= BUBBLE;
                    out_vld_q <= 1'b0;
                    occ_q     <= 2'd0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Bench for pipeline_stage_register. A queue model sits alongside the DUT, and
// every cycle the DUT outputs are compared with it. Directed steps also check
// hand-computed literal values, which pin the model itself.
// Follows PIPELINE_SKID_BUFFER_EN in the same way as the design.
module tb_pipeline_stage_register;
    localparam int CW = 12;
    localparam int DW = 192;
    localparam logic [DW-1:0] BUB = {24{8'h2A}};

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Flush = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [CW-1:0] In_Ctrl = '0;
    logic [DW-1:0] In_Data = '0;
    logic          Out_Valid;
    logic          Out_Ready = 1'b0;
    logic [CW-1:0] Out_Ctrl;
    logic [DW-1:0] Out_Data;
    logic [1:0]    Occupancy;

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 1'b0;

    pipeline_stage_register #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_BYTE(8'h2A)) dut (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl),
        .Out_Data(Out_Data), .Occupancy(Occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [DW-1:0] mk_data(input int t);
        logic [31:0] w;
        w = t;
        return {6{w ^ 32'h5A5A0000}};
    endfunction

    // ---------------- behavioural model: an ordered queue of held entries
    logic [CW+DW-1:0] q[$];
    logic [CW+DW-1:0] exp_e;
    logic [CW+DW-1:0] prev_out;
    bit               stall_prev = 1'b0;
    bit               m_push;
    bit               m_pop;

    function automatic bit model_rdy();
`ifdef PIPELINE_SKID_BUFFER_EN
        return q.size() < 2;
`else
        return q.size() == 0 || Out_Ready;
`endif
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST || Flush) begin
            q.delete();
        end else begin
            m_push = In_Valid && model_rdy();
            m_pop  = q.size() > 0 && Out_Ready;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back({In_Ctrl, In_Data});
        end
    end

    // ---------------- compare process, mid-cycle away from the active edge
    always @(negedge CLK) begin
        if (run) begin
            exp_e = (q.size() > 0) ? q[0] : {{CW{1'b0}}, BUB};
            chk("in_ready",  In_Ready,  model_rdy());
            chk("out_valid", Out_Valid, q.size() > 0);
            chk("occupancy", Occupancy, q.size());
            chk("out_ctrl",  Out_Ctrl,  exp_e[CW+DW-1:DW]);
            chk("out_data",  Out_Data,  exp_e[DW-1:0]);
            if (stall_prev && q.size() > 0) chk("stall_hold", {Out_Ctrl, Out_Data}, prev_out);
            stall_prev = q.size() > 0 && !Out_Ready && !Flush;
            prev_out   = {Out_Ctrl, Out_Data};
        end
    end

    // Apply one set of inputs across one rising edge; returns 2 time units after it.
    task automatic drive(input bit v, input int tag, input bit ordy, input bit fl);
        logic [31:0] w;
        w = tag;
        In_Valid  = v;
        In_Ctrl   = w[CW-1:0];
        In_Data   = mk_data(tag);
        Out_Ready = ordy;
        Flush     = fl;
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #1 RST = 1'b1;
        #8;
        chk("rst_valid", Out_Valid, 1'b0);
        chk("rst_occ",   Occupancy, 2'd0);
        chk("rst_ctrl",  Out_Ctrl,  12'h000);
        chk("rst_data",  Out_Data,  BUB);
        @(posedge CLK);
        #2 RST = 1'b0;
        run = 1'b1;

        // Asynchronous reset pulse while holding 0xABC
        drive(1, 32'hABC, 0, 0);
        chk("lat1_valid", Out_Valid, 1'b1);
        chk("lat1_ctrl",  Out_Ctrl,  12'hABC);
        #1 RST = 1'b1;
        #1;
        chk("arst_valid", Out_Valid, 1'b0);
        chk("arst_ctrl",  Out_Ctrl,  12'h000);
        chk("arst_data",  Out_Data,  BUB);
        chk("arst_occ",   Occupancy, 2'd0);
        RST = 1'b0;

        // A, B, C offered against a stalled downstream, then released
        drive(1, 32'h0A1, 0, 0);
        chk("abc1_occ",  Occupancy, 2'd1);
        chk("abc1_ctrl", Out_Ctrl,  12'h0A1);
        drive(1, 32'h0B2, 0, 0);
`ifdef PIPELINE_SKID_BUFFER_EN
        chk("abc2_occ",  Occupancy, 2'd2);
        chk("abc2_rdy",  In_Ready,  1'b0);
`else
        chk("abc2_occ",  Occupancy, 2'd1);
`endif
        chk("abc2_ctrl", Out_Ctrl,  12'h0A1);
        drive(1, 32'h0C3, 0, 0);
        chk("abc3_ctrl", Out_Ctrl,  12'h0A1);
        drive(1, 32'h0C3, 1, 0);
`ifdef PIPELINE_SKID_BUFFER_EN
        chk("abc4_ctrl", Out_Ctrl,  12'h0B2);
        chk("abc4_rdy",  In_Ready,  1'b1);
`else
        chk("abc4_ctrl", Out_Ctrl,  12'h0C3);
`endif
        chk("abc4_occ",  Occupancy, 2'd1);
        drive(1, 32'h0C3, 1, 0);
        chk("abc5_ctrl", Out_Ctrl,  12'h0C3);
        chk("abc5_data", Out_Data,  mk_data(32'h0C3));
        drive(0, 0, 1, 0);
        chk("abc6_valid", Out_Valid, 1'b0);
        chk("abc6_occ",   Occupancy, 2'd0);

        // Flush while holding entries, with an entry offered at the same edge
        drive(1, 32'h0D4, 0, 0);
        drive(1, 32'h0E5, 0, 0);
        drive(1, 32'h0F6, 1, 1);
        chk("flush_occ",   Occupancy, 2'd0);
        chk("flush_valid", Out_Valid, 1'b0);
        chk("flush_ctrl",  Out_Ctrl,  12'h000);
        chk("flush_data",  Out_Data,  BUB);
        drive(0, 0, 1, 0);
        chk("flush_gone",  Out_Valid, 1'b0);

        // Streaming with downstream always ready: one per cycle at latency 1
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h300 + i, 1, 0);
            chk("stream_ctrl", Out_Ctrl,  CW'(32'h300 + i));
            chk("stream_occ",  Occupancy, 2'd1);
        end
        drive(0, 0, 1, 0);

        // Random handshakes; the model and the compare process carry the checks
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 32'h400 + i, 1'($urandom_range(0, 3) != 0), 0);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
        chk("drain_valid", Out_Valid, 1'b0);

        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipeline_stage_register.md
PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

Interface
REQ-001 Parameter CTRL_W, default 12: width of the control field (enables/selects), zeroed on bubble.
REQ-002 Parameter DATA_W, default 192: width of the data field (PC, operands, immediates); SHALL be a multiple of 8.
REQ-003 Parameter BUBBLE_BYTE, default 8'h2A: byte replicated across the data field to mark a bubble.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 Flush  input  1  discard all held entries at the next edge.
REQ-007 In_Valid  input  1  upstream presents an entry.
REQ-008 In_Ready  output  1  stage accepts an entry this cycle.
REQ-009 In_Ctrl  input  CTRL_W  upstream control field.
REQ-010 In_Data  input  DATA_W  upstream data field.
REQ-011 Out_Valid  output  1  stage presents an entry downstream.
REQ-012 Out_Ready  input  1  downstream accepts the entry.
REQ-013 Out_Ctrl  output  CTRL_W  registered control field.
REQ-014 Out_Data  output  DATA_W  registered data field.
REQ-015 Occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 Push = In_Valid && In_Ready; pop = Out_Valid && Out_Ready; both SHALL be evaluated at the same rising edge.
REQ-017 States: EMPTY (Occupancy 0), ONE (Occupancy 1), FULL (Occupancy 2); Out_Valid SHALL be 1 in ONE and FULL only.
REQ-018 EMPTY: push -> ONE with the output entry loaded; latency In to Out is exactly 1 cycle.
REQ-019 ONE: push and pop -> ONE with the output entry replaced; push only -> FULL with the skid entry loaded; pop only -> EMPTY.
REQ-020 FULL: pop -> ONE with the output entry taken from the skid entry; no push is possible (In_Ready 0).
REQ-021 Entries SHALL leave in arrival order; no entry SHALL be dropped or duplicated unless Flush or RST is asserted.
REQ-022 In EMPTY, Out_Ctrl SHALL be all-zero and Out_Data SHALL be BUBBLE_BYTE replicated (default 0x2A2A...2A).
REQ-023 Flush at an edge SHALL force EMPTY, overriding any simultaneous push or pop; an entry offered in that cycle is discarded.
REQ-024 Out_Valid, Out_Ctrl, Out_Data and Occupancy SHALL be driven from registers only; no combinational path from In_* to Out_*.
REQ-025 Out_Ctrl and Out_Data SHALL be held stable while Out_Valid = 1 and Out_Ready = 0.

Reset
REQ-026 RST asserted SHALL immediately force EMPTY: Out_Valid 0, Occupancy 0, Out_Ctrl 0, Out_Data bubble pattern, skid entry invalid.
REQ-027 RST asserted mid-transfer SHALL discard all held entries; the first push after RST deasserts SHALL be accepted normally.
REQ-028 RST SHALL take priority over Flush and all handshakes.

Configuration
REQ-029 Macro PIPELINE_SKID_BUFFER_EN defined: two-entry skid buffer per REQ-017..020; In_Ready = not FULL, registered, with no combinational dependence on Out_Ready.
REQ-030 Macro PIPELINE_SKID_BUFFER_EN undefined: single entry only; FULL unreachable; In_Ready = !Out_Valid || Out_Ready (combinational); Occupancy never exceeds 1; all other requirements unchanged.

Verification
REQ-031 RST pulse while in ONE with Out_Ctrl 0xABC -> Out_Valid 0, Out_Ctrl 0x000, Out_Data 0x2A..2A, Occupancy 0 before the next edge.
REQ-032 Push A, B, C on consecutive cycles with Out_Ready 0 (skid enabled) -> Occupancy 1 then 2, In_Ready 0 after B, C not accepted; raise Out_Ready -> outputs A then B, C accepted once In_Ready returns to 1.
REQ-033 Flush asserted in FULL with a simultaneous In_Valid -> next cycle Occupancy 0, Out_Valid 0, Out_Ctrl 0, Out_Data 0x2A..2A; the offered entry never appears at the output.
REQ-034 Continuous random In_Valid/Out_Ready for 1000 cycles -> output sequence equals accepted input sequence; no loss or reordering; REQ-025 holds every stalled cycle.
REQ-035 Macro undefined, Out_Ready held 1, push every cycle -> one entry out per cycle at latency 1; Occupancy never 2.
